test_run_controller: RTL and testbench

TEST_RUN_CONTROLLER -- requirements
Module: test_run_controller

---
 rtl/test_run_controller_if.sv | 13 +
 rtl/test_run_controller.sv | 141 ++++++++++++++
 tb/tb_test_run_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/test_run_controller_if.sv
// Store bus between the device under test and the run controller.
// The CPU side drives stores; the controller drives the CPU reset.
interface test_run_controller_if #(
  parameter int WIDTH = 32
);
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;
  logic             cpu_reset;

  modport master (output memwrite, dataadr, writedata, input cpu_reset);
  modport slave  (input memwrite, dataadr, writedata, output cpu_reset);
endinterface

// File: rtl/test_run_controller.sv
// Sequences a CPU test run: holds the CPU in reset, lets it run, and reports
// pass/fail from a store to PASS_ADDR, or a timeout when none arrives in time.
module test_run_controller #(
  parameter int               WIDTH          = 32,
  parameter int               CNT_W          = 32,
  parameter int               RESET_CYCLES   = 2,
  parameter int               TIMEOUT_CYCLES = 25,
  parameter logic [WIDTH-1:0] PASS_ADDR      = 84,
  parameter logic [WIDTH-1:0] PASS_DATA      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  test_run_controller_if.slave  bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      write_count,
  output logic [WIDTH-1:0]      last_adr,
  output logic [WIDTH-1:0]      last_data
);

  localparam int               HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   writes_q, writes_d;
  logic [WIDTH-1:0]   adr_q, adr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic               verdict_store;
  logic               clear_run;

  assign verdict_store = bus.memwrite && (bus.dataadr == PASS_ADDR);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    writes_d  = writes_q;
    adr_d     = adr_q;
    data_d    = data_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    clear_run = 1'b0;

    case (state_q)
      IDLE: clear_run = start;
      DONE: clear_run = start;
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (bus.memwrite && (writes_q != {CNT_W{1'b1}})) begin
          writes_d = writes_q + CNT_W'(1);
        end
        // A verdict store on the last allowed cycle takes priority over timeout.
        if (verdict_store) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (bus.writedata == PASS_DATA);
          fail_d  = (bus.writedata != PASS_DATA);
          adr_d   = bus.dataadr;
          data_d  = bus.writedata;
        end else if (cycle_q == TO_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_run) begin
      state_d   = HOLD;
      hold_d    = '0;
      cycle_d   = '0;
      writes_d  = '0;
      adr_d     = '0;
      data_d    = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      cycle_q   <= '0;
      writes_q  <= '0;
      adr_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      writes_q  <= writes_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cpu_reset = (state_q != RUN);
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_q;
  assign write_count   = writes_q;
  assign last_adr      = adr_q;
  assign last_data     = data_q;

endmodule

// File: tb/tb_test_run_controller.sv
// Randomized self-checking bench for test_run_controller: each run's store
// schedule is scored by a plain verdict model before the run is driven.
module tb_test_run_controller;

  localparam int          WIDTH = 32;
  localparam int          CNT_W = 32;
  localparam int          RC    = 2;
  localparam int          TO    = 25;
  localparam logic [31:0] PA    = 84;
  localparam logic [31:0] PD    = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              done, pass, fail, timeout;
  logic [CNT_W-1:0]  cycle_count, write_count;
  logic [WIDTH-1:0]  last_adr, last_data;

  int n_pass  = 0;
  int n_total = 0;

  logic              sch_we  [TO];
  logic [WIDTH-1:0]  sch_adr [TO];
  logic [WIDTH-1:0]  sch_dat [TO];
  int                start_at;

  always #5 clk = ~clk;

  test_run_controller_if #(.WIDTH(WIDTH)) bus ();

  test_run_controller #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO),
    .PASS_ADDR(PA), .PASS_DATA(PD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .write_count(write_count),
    .last_adr(last_adr), .last_data(last_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched;
    for (int i = 0; i < TO; i++) begin
      sch_we[i]  = 1'b0;
      sch_adr[i] = '0;
      sch_dat[i] = '0;
    end
    start_at = -1;
  endtask

  // Start a run from IDLE or DONE, drive the schedule, and check the verdict.
  task automatic do_run(input string name);
    int          len, kind;
    logic [31:0] e_wc, e_adr, e_dat;
    logic [31:0] h_cc, h_wc, h_adr, h_dat;
    logic [3:0]  h_flags;
    len = TO; kind = 2; e_wc = 0; e_adr = 0; e_dat = 0;
    for (int k = 0; k < TO; k++) begin
      if (sch_we[k]) begin
        e_wc++;
        if (sch_adr[k] == PA) begin
          kind  = (sch_dat[k] == PD) ? 0 : 1;
          len   = k + 1;
          e_adr = sch_adr[k];
          e_dat = sch_dat[k];
          break;
        end
      end
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int h = 0; h < RC; h++) begin
      n_total++;
      if (bus.cpu_reset !== 1'b1 || {done, pass, fail, timeout} !== 4'b0000 ||
          cycle_count !== 0 || write_count !== 0 || last_adr !== 0 || last_data !== 0) begin
        $display("FAIL %s hold%0d: cpu_reset=%b flags=%b cc=%0d wc=%0d adr=%0d dat=%0d, required cpu_reset=1 and all cleared",
                 name, h, bus.cpu_reset, {done, pass, fail, timeout}, cycle_count, write_count, last_adr, last_data);
      end else n_pass++;
      bus.memwrite  = 1'b1;
      bus.dataadr   = PA;
      bus.writedata = PD;
      tick();
    end

    for (int k = 0; k < len; k++) begin
      n_total++;
      if (bus.cpu_reset !== 1'b0 || done !== 1'b0 || cycle_count !== k) begin
        $display("FAIL %s run%0d: cpu_reset=%b done=%b cc=%0d, required cpu_reset=0 done=0 cc=%0d",
                 name, k, bus.cpu_reset, done, cycle_count, k);
      end else n_pass++;
      bus.memwrite  = sch_we[k];
      bus.dataadr   = sch_adr[k];
      bus.writedata = sch_dat[k];
      start         = (k == start_at);
      tick();
    end
    start = 1'b0;
    bus.memwrite = 1'b0;

    // Verdict checked once on arrival and again after stray stores in DONE.
    for (int rep = 0; rep < 2; rep++) begin
      n_total++;
      if (bus.cpu_reset !== 1'b1 || done !== 1'b1 || pass !== (kind == 0) || fail !== (kind == 1) ||
          timeout !== (kind == 2) || cycle_count !== len || write_count !== e_wc ||
          last_adr !== e_adr || last_data !== e_dat) begin
        $display("FAIL %s verdict%0d: cpu_reset=%b d/p/f/t=%b%b%b%b cc=%0d wc=%0d adr=%0d dat=%0d, required cpu_reset=1 d/p/f/t=1%b%b%b cc=%0d wc=%0d adr=%0d dat=%0d",
                 name, rep, bus.cpu_reset, done, pass, fail, timeout, cycle_count, write_count, last_adr, last_data,
                 (kind == 0), (kind == 1), (kind == 2), len, e_wc, e_adr, e_dat);
      end else n_pass++;
      if (rep == 0) begin
        for (int s = 0; s < 3; s++) begin
          bus.memwrite  = 1'b1;
          bus.dataadr   = (s == 0) ? PA : 32'd80;
          bus.writedata = $urandom_range(0, 15);
          tick();
        end
        bus.memwrite = 1'b0;
      end
    end
    h_cc = cycle_count; h_wc = write_count; h_adr = last_adr; h_dat = last_data;
    h_flags = {done, pass, fail, timeout};
    $display("run %s: len=%0d verdict=%0d flags=%b cc=%0d wc=%0d adr=%0d dat=%0d",
             name, len, kind, h_flags, h_cc, h_wc, h_adr, h_dat);
  endtask

  task automatic check_idle(input string name);
    n_total++;
    if (bus.cpu_reset !== 1'b1 || {done, pass, fail, timeout} !== 4'b0000 ||
        cycle_count !== 0 || write_count !== 0 || last_adr !== 0 || last_data !== 0) begin
      $display("FAIL %s: cpu_reset=%b flags=%b cc=%0d wc=%0d adr=%0d dat=%0d, required 1/0000/0/0/0/0",
               name, bus.cpu_reset, {done, pass, fail, timeout}, cycle_count, write_count, last_adr, last_data);
    end else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0;
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    #23;
    check_idle("reset_asserted");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.memwrite = 1'b1; bus.dataadr = PA; bus.writedata = PD;
      tick();
    end
    bus.memwrite = 1'b0;
    check_idle("idle_after_release");
  endtask

  task automatic test_pass;
    clear_sched();
    sch_we[1] = 1'b1; sch_adr[1] = 80; sch_dat[1] = 3;
    sch_we[5] = 1'b1; sch_adr[5] = PA; sch_dat[5] = PD;
    do_run("pass_cycle5");
  endtask

  task automatic test_fail;
    clear_sched();
    sch_we[3] = 1'b1; sch_adr[3] = PA; sch_dat[3] = 9;
    do_run("fail_data9");
  endtask

  task automatic test_timeout;
    clear_sched();
    sch_we[2]  = 1'b1; sch_adr[2]  = 80; sch_dat[2]  = 7;
    sch_we[10] = 1'b1; sch_adr[10] = 80; sch_dat[10] = 1;
    sch_we[20] = 1'b1; sch_adr[20] = 80; sch_dat[20] = 2;
    do_run("timeout_3stores");
  endtask

  task automatic test_verdict_at_timeout;
    clear_sched();
    sch_we[TO-1] = 1'b1; sch_adr[TO-1] = PA; sch_dat[TO-1] = PD;
    do_run("pass_last_cycle");
    clear_sched();
    sch_we[TO-1] = 1'b1; sch_adr[TO-1] = PA; sch_dat[TO-1] = 5;
    do_run("fail_last_cycle");
  endtask

  task automatic test_ignored_start;
    clear_sched();
    start_at = 4;
    sch_we[8] = 1'b1; sch_adr[8] = PA; sch_dat[8] = PD;
    do_run("start_in_run");
  endtask

  task automatic test_random;
    for (int r = 0; r < 10; r++) begin
      clear_sched();
      for (int k = 0; k < TO; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          int sel;
          sel        = $urandom_range(0, 19);
          sch_we[k]  = 1'b1;
          sch_adr[k] = (sel == 0) ? PA : (sel < 10) ? 32'd80 : ($urandom | 32'h100);
          sch_dat[k] = $urandom_range(0, 1) ? PD : 32'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 1) == 1) start_at = $urandom_range(0, TO - 1);
      do_run($sformatf("random%0d", r));
    end
  endtask

  task automatic test_midrun_reset;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int h = 0; h < RC; h++) tick();
    for (int k = 0; k < 10; k++) begin
      bus.memwrite = k[0]; bus.dataadr = 80; bus.writedata = PD;
      tick();
    end
    bus.memwrite = 1'b0;
    n_total++;
    if (cycle_count !== 10 || write_count !== 5 || bus.cpu_reset !== 1'b0) begin
      $display("FAIL midrun_pre: cc=%0d wc=%0d cpu_reset=%b, required cc=10 wc=5 cpu_reset=0",
               cycle_count, write_count, bus.cpu_reset);
    end else n_pass++;
    #2 reset = 1'b0;
    #1 check_idle("midrun_reset_async");
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_idle("midrun_reset_stays_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_verdict_at_timeout();
    test_ignored_start();
    test_random();
    test_midrun_reset();
    test_pass();
    test_fail();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
